// File: rtl/cp0_ext.sv
// Coprocessor-0 subset: SR/Cause/EPC exception bookkeeping, BadVAddr capture and a Count/Compare timer.
// The request, interrupt acknowledge, EPC output and read data are combinational; all state updates on clk.
module cp0_ext #(
  parameter int          NUM_HWINT = 5,
  parameter int          TIMER_EN  = 1,
  parameter logic [31:0] PRID_VAL  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 we,
  input  logic                 exl_clr,
  input  logic                 bd_in,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wdata,
  input  logic [31:0]          epc_in,
  input  logic [4:0]           exc_code_in,
  input  logic [31:0]          badvaddr_in,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic                 req,
  output logic [31:0]          rdata,
  output logic [31:0]          epc_out,
  output logic                 int_ack,
  output logic                 timer_irq
);

  logic [7:0]  srIm_q,     srIm_d;
  logic        srExl_q,    srExl_d;
  logic        srIe_q,     srIe_d;
  logic        causeBd_q,  causeBd_d;
  logic        causeTi_q,  causeTi_d;
  logic [1:0]  causeSw_q,  causeSw_d;
  logic [4:0]  causeHw_q,  causeHw_d;
  logic [4:0]  excCode_q,  excCode_d;
  logic [31:0] epc_q,      epc_d;
  logic [31:0] badVAddr_q, badVAddr_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic        phase_q,    phase_d;

  logic [4:0]  hwExt;
  logic [7:0]  ipBits;
  logic        intTake;
  logic        excTake;
  logic        wrEn;

  // Unused upper hardware-interrupt positions stay zero when NUM_HWINT < 5.
  always_comb begin
    hwExt = '0;
    for (int k = 0; k < NUM_HWINT; k++) hwExt[k] = hwint[k];
  end

  always_comb begin
    ipBits    = {causeTi_q, causeHw_q, causeSw_q};
    intTake   = (|(ipBits & srIm_q)) & srIe_q & ~srExl_q;
    excTake   = (exc_code_in != 5'd0) & ~srExl_q;
    req       = intTake | excTake;
    int_ack   = intTake;
    epc_out   = req ? (bd_in ? epc_in - 32'd4 : epc_in) : epc_q;
    wrEn      = we & ~req;
    timer_irq = causeTi_q;
  end

  always_comb begin
    rdata = 32'd0;
    case (rd_addr)
      5'd8:    rdata = badVAddr_q;
      5'd9:    rdata = count_q;
      5'd11:   rdata = compare_q;
      5'd12:   rdata = {16'd0, srIm_q, 6'd0, srExl_q, srIe_q};
      5'd13:   rdata = {causeBd_q, causeTi_q, 14'd0, ipBits, 1'b0, excCode_q, 2'b00};
      5'd14:   rdata = epc_q;
      5'd15:   rdata = PRID_VAL;
      default: rdata = 32'd0;
    endcase
  end

  // A Count write restarts the two-cycle prescale; a Compare write clears TI even if it was just set.
  always_comb begin
    srIm_d     = srIm_q;
    srExl_d    = srExl_q;
    srIe_d     = srIe_q;
    causeBd_d  = causeBd_q;
    causeTi_d  = causeTi_q;
    causeSw_d  = causeSw_q;
    causeHw_d  = hwExt;
    excCode_d  = excCode_q;
    epc_d      = epc_q;
    badVAddr_d = badVAddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    phase_d    = phase_q;

    if (TIMER_EN != 0) begin
      if (wrEn && wr_addr == 5'd9) begin
        count_d = wdata;
        phase_d = 1'b0;
      end else begin
        phase_d = ~phase_q;
        if (phase_q) begin
          count_d = count_q + 32'd1;
          if (count_d == compare_q) causeTi_d = 1'b1;
        end
      end
    end

    if (wrEn && wr_addr == 5'd11) begin
      compare_d = wdata;
      causeTi_d = 1'b0;
    end
    if (wrEn && wr_addr == 5'd12) begin
      srIm_d  = wdata[15:8];
      srExl_d = wdata[1];
      srIe_d  = wdata[0];
    end
    if (exl_clr && !req) srExl_d = 1'b0;
    if (wrEn && wr_addr == 5'd13) causeSw_d = wdata[9:8];
    if (wrEn && wr_addr == 5'd14) epc_d = wdata;

    // Interrupts win over synchronous exceptions and report ExcCode 0.
    if (req) begin
      srExl_d   = 1'b1;
      causeBd_d = bd_in;
      epc_d     = epc_out;
      excCode_d = intTake ? 5'd0 : exc_code_in;
      if (!intTake && (exc_code_in == 5'd4 || exc_code_in == 5'd5)) badVAddr_d = badvaddr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      srIm_q     <= '0;
      srExl_q    <= 1'b0;
      srIe_q     <= 1'b0;
      causeBd_q  <= 1'b0;
      causeTi_q  <= 1'b0;
      causeSw_q  <= '0;
      causeHw_q  <= '0;
      excCode_q  <= '0;
      epc_q      <= '0;
      badVAddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      phase_q    <= 1'b0;
    end else begin
      srIm_q     <= srIm_d;
      srExl_q    <= srExl_d;
      srIe_q     <= srIe_d;
      causeBd_q  <= causeBd_d;
      causeTi_q  <= causeTi_d;
      causeSw_q  <= causeSw_d;
      causeHw_q  <= causeHw_d;
      excCode_q  <= excCode_d;
      epc_q      <= epc_d;
      badVAddr_q <= badVAddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      phase_q    <= phase_d;
    end
  end

endmodule
